// File: rtl/dac_spi_tx_pkg.sv
// Shared constants and types for the DAC SPI transmitter: frame layout, divider presets,
// DAC control codes and FSM state encoding.
package dac_spi_tx_pkg;

    localparam int unsigned FrameBits = 16;
    localparam int unsigned CtrlBits  = 4;
    localparam int unsigned DataBits  = 12;

    // 2.4 MHz SCLK from a 48 MHz system clock
    localparam int unsigned Sclk2m4Clk48m = 10;

    localparam logic [CtrlBits-1:0] DacCtrlNormal  = 4'b0000;
    localparam logic [CtrlBits-1:0] DacCtrlPd1k    = 4'b0100;
    localparam logic [CtrlBits-1:0] DacCtrlPd100k  = 4'b1000;
    localparam logic [CtrlBits-1:0] DacCtrlPdHiz   = 4'b1100;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    function automatic logic [FrameBits-1:0] frame_word(logic [CtrlBits-1:0] ctrl,
                                                        logic [DataBits-1:0] value);
        return {ctrl, value};
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Request/status and DAC pin bundle of the DAC SPI transmitter.
// master = control logic issuing writes, slave = the transmitter.
interface dac_spi_tx_if;
    import dac_spi_tx_pkg::*;

    logic [DataBits-1:0] value;
    logic [CtrlBits-1:0] ctrl;
    logic                write;
    logic                busy;
    logic                write_done;
    logic                cs;
    logic                sclk;
    logic                sdi;

    modport master (
        output value, ctrl, write,
        input  busy, write_done, cs, sclk, sdi
    );

    modport slave (
        input  value, ctrl, write,
        output busy, write_done, cs, sclk, sdi
    );

endinterface

// File: rtl/dac_spi_tx_half_period_tick.sv
// Clock-enable generator: tick is high for one clk every CLK_DIV cycles, counting from a
// synchronous clear.
module dac_spi_tx_half_period_tick #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    assign tick = (div_cnt_q == CntW'(CLK_DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (clear || tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI master writing one 16-bit frame (4 ctrl + 12 data, MSB first) to a serial DAC.
// SCLK idles high; sdi changes on SCLK rising edges, the DAC samples on falling edges.
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = Sclk2m4Clk48m,
    parameter int unsigned GAP_CYCLES = 4
) (
    input logic          clk,
    input logic          reset,
    dac_spi_tx_if.slave  bus
);

    localparam int unsigned BitW = $clog2(FrameBits);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [FrameBits-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]      gap_cnt_q, gap_cnt_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 sdi_q, sdi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;

    // Divider is held at zero in idle so the first falling edge lands CLK_DIV after accept
    dac_spi_tx_half_period_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .clear (reset || (state_q == StIdle)),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.write) begin
                    shift_d   = frame_word(bus.ctrl, bus.value);
                    cs_d      = 1'b0;
                    sdi_d     = bus.ctrl[CtrlBits-1];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (bit_cnt_q == BitW'(FrameBits - 1)) begin
                            sdi_d   = 1'b0;
                            state_d = StHold;
                        end else begin
                            shift_d   = {shift_q[FrameBits-2:0], 1'b0};
                            sdi_d     = shift_q[FrameBits-2];
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b1;
            sdi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.cs         = cs_q;
    assign bus.sclk       = sclk_q;
    assign bus.sdi        = sdi_q;
    assign bus.busy       = busy_q;
    assign bus.write_done = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: one instance at CLK_DIV=10 and one at CLK_DIV=1.
// Stimulus pushes expected frames; a negedge monitor decodes the pins and pops on write_done.
module tb_dac_spi_tx;
    import dac_spi_tx_pkg::*;

    localparam int unsigned DivA = 10;
    localparam int unsigned DivB = 1;
    localparam int unsigned Gap  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dac_spi_tx_if ifa ();
    dac_spi_tx_if ifb ();

    dac_spi_tx #(
        .CLK_DIV    (DivA),
        .GAP_CYCLES (Gap)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    dac_spi_tx #(
        .CLK_DIV    (DivB),
        .GAP_CYCLES (Gap)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] q_a [$];
    logic [15:0] q_b [$];

    logic        prev_cs   [2];
    logic        prev_sclk [2];
    logic        prev_sdi  [2];
    logic [15:0] shreg     [2];
    int          falls     [2];
    int          cs_low    [2];
    int          cs_high   [2];
    int          gapcnt    [2];
    int          done_cnt  [2] = '{0, 0};
    int          glitch    [2];
    bit          in_gap    [2];
    bit          seen      [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int i, input logic cs, input logic sclk, input logic sdi,
                       input logic busy, input logic done, input int div);
        logic [15:0] exp_w;
        if (reset) begin
            shreg[i]   = '0;
            falls[i]   = 0;
            cs_low[i]  = 0;
            cs_high[i] = 0;
            glitch[i]  = 0;
            in_gap[i]  = 1'b0;
            seen[i]    = 1'b0;
        end else begin
            if (!cs) begin
                cs_low[i]++;
                if (prev_sclk[i] && !sclk) begin
                    shreg[i] = {shreg[i][14:0], sdi};
                    falls[i]++;
                end
            end
            if (cs && !sclk) glitch[i]++;
            // sdi may only move with an SCLK rise or with the accept (cs fall)
            if ((sdi !== prev_sdi[i]) && !(sclk && !prev_sclk[i]) && !(prev_cs[i] && !cs))
                glitch[i]++;
            if (i == 1 && seen[1] && prev_cs[1] && !cs)
                check("cs_high_between_frames", cs_high[1], Gap + 1);
            cs_high[i] = cs ? cs_high[i] + 1 : 0;
            if (done) begin
                done_cnt[i]++;
                exp_w = 'x;
                if (i == 0) begin
                    check($sformatf("sb_has_entry[%0d]", i), 32'(q_a.size() != 0), 1);
                    if (q_a.size() != 0) exp_w = q_a.pop_front();
                end else begin
                    check($sformatf("sb_has_entry[%0d]", i), 32'(q_b.size() != 0), 1);
                    if (q_b.size() != 0) exp_w = q_b.pop_front();
                end
                check($sformatf("frame_word[%0d]", i), 32'(shreg[i]), 32'(exp_w));
                check($sformatf("falling_edges[%0d]", i), falls[i], 16);
                check($sformatf("cs_low_cycles[%0d]", i), cs_low[i], 33 * div);
                check($sformatf("done_at_cs_rise[%0d]", i), {30'd0, cs, prev_cs[i]}, 2);
                check($sformatf("pin_discipline[%0d]", i), glitch[i], 0);
                shreg[i]  = '0;
                falls[i]  = 0;
                cs_low[i] = 0;
                glitch[i] = 0;
                in_gap[i] = 1'b1;
                gapcnt[i] = 0;
                seen[i]   = 1'b1;
            end
            if (in_gap[i]) begin
                if (busy) begin
                    gapcnt[i]++;
                end else begin
                    check($sformatf("busy_after_cs_rise[%0d]", i), gapcnt[i], Gap);
                    in_gap[i] = 1'b0;
                end
            end
        end
        prev_cs[i]   = cs;
        prev_sclk[i] = sclk;
        prev_sdi[i]  = sdi;
    endtask

    always @(negedge clk) begin
        mon(0, ifa.cs, ifa.sclk, ifa.sdi, ifa.busy, ifa.write_done, DivA);
        mon(1, ifb.cs, ifb.sclk, ifb.sdi, ifb.busy, ifb.write_done, DivB);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [11:0] val, input logic [3:0] ctl);
        ifa.value = val;
        ifa.ctrl  = ctl;
        ifa.write = 1'b1;
        q_a.push_back({ctl, val});
        step(1);
        ifa.write = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int t = 0;
        while (((i == 0) ? ifa.busy : ifb.busy) !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("idle_within_budget[%0d]", i), (i == 0) ? ifa.busy : ifb.busy, 0);
        step(2);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_cs"}, ifa.cs, 1);
        check({tag, "_sclk"}, ifa.sclk, 1);
        check({tag, "_sdi"}, ifa.sdi, 0);
        check({tag, "_busy"}, ifa.busy, 0);
        check({tag, "_write_done"}, ifa.write_done, 0);
    endtask

    initial begin
        int d0;
        int t;
        ifa.write = 1'b0; ifa.value = '0; ifa.ctrl = '0;
        ifb.write = 1'b0; ifb.value = '0; ifb.ctrl = '0;
        reset = 1'b1;
        step(3);
        check_reset_pins("reset");
        reset = 1'b0;
        step(2);

        // Basic frame
        write_a(12'hA5C, DacCtrlNormal);
        wait_idle(0, 400);

        // Second write mid-frame must be dropped
        d0 = done_cnt[0];
        write_a(12'hA5C, DacCtrlNormal);
        step(100);
        ifa.value = 12'h123;
        ifa.write = 1'b1;
        step(1);
        ifa.write = 1'b0;
        wait_idle(0, 400);
        check("write_while_busy_done_count", done_cnt[0] - d0, 1);
        check("write_while_busy_queue_empty", q_a.size(), 0);

        // Reset after the 7th falling edge aborts silently
        write_a(12'h5A3, DacCtrlPd100k);
        t = 0;
        while (falls[0] < 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("seven_falls_reached", falls[0], 7);
        reset = 1'b1;
        step(1);
        check_reset_pins("abort");
        step(1);
        reset = 1'b0;
        void'(q_a.pop_back());
        d0 = done_cnt[0];
        step(40);
        check("abort_no_write_done", done_cnt[0] - d0, 0);
        write_a(12'h5A3, DacCtrlPd100k);
        wait_idle(0, 400);

        // Inputs churn every clock during the frame
        write_a(12'h3C7, DacCtrlPd1k);
        for (int k = 0; k < 400 && ifa.busy; k++) begin
            ifa.value = ifa.value ^ 12'hFFF;
            ifa.ctrl  = ifa.ctrl + 4'd1;
            step(1);
        end
        wait_idle(0, 10);

        // Continuous write at CLK_DIV=1: accepts at k, k+38, k+76; released before k+114
        ifb.value = 12'hFFF;
        ifb.ctrl  = DacCtrlPdHiz;
        ifb.write = 1'b1;
        repeat (3) q_b.push_back(16'hCFFF);
        step(1);
        step(94);
        ifb.write = 1'b0;
        wait_idle(1, 200);
        check("continuous_done_count", done_cnt[1], 3);
        check("continuous_queue_empty", q_b.size(), 0);
        check("final_queue_a_empty", q_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
